bus_initiator: RTL and testbench

// Root initiator for the local register bus: the master end that bus slave registers answer.
// It accepts one host command at a time (read or write) and drives the packed bus_in vector.
// It then collects the OR-combined bus_out from all slaves and returns read data or a timeout

---
 rtl/bus_initiator_pkg.sv | 32 +++
 rtl/bus_initiator_if.sv | 29 ++
 rtl/bus_initiator.sv | 164 ++++++++++++++++
 tb/tb_bus_initiator.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_initiator_pkg.sv
// Shared widths and bus field positions for the local register bus.
// The bus_in / bus_out layouts must match what the slave register side decodes.
package bus_initiator_pkg;

  localparam int BUS_ADDR_WIDTH = 16;
  localparam int BUS_DATA_WIDTH = 32;

  // bus_in: initiator -> slaves
  localparam int BUS_FIELD_CLK      = 0;
  localparam int BUS_FIELD_RESET_L  = 1;
  localparam int BUS_FIELD_RE       = 2;
  localparam int BUS_FIELD_WE       = 3;
  localparam int BUS_ADDR_START     = 4;
  localparam int BUS_ADDR_END       = BUS_ADDR_START + BUS_ADDR_WIDTH - 1;
  localparam int BUS_WR_DATA_START  = BUS_ADDR_END + 1;
  localparam int BUS_WR_DATA_END    = BUS_WR_DATA_START + BUS_DATA_WIDTH - 1;
  localparam int BUS_IN_WIDTH       = BUS_WR_DATA_END + 1;

  // bus_out: OR of all slaves -> initiator
  localparam int BUS_FIELD_RD_ACK   = 0;
  localparam int BUS_FIELD_WR_ACK   = 1;
  localparam int BUS_FIELD_IRQ      = 2;
  localparam int BUS_RD_DATA_START  = 3;
  localparam int BUS_RD_DATA_END    = BUS_RD_DATA_START + BUS_DATA_WIDTH - 1;
  localparam int BUS_OUT_WIDTH      = BUS_RD_DATA_END + 1;

  // Registers are word-aligned; the two byte-lane bits never reach the bus.
  function automatic logic [BUS_ADDR_WIDTH-1:0] word_align(input logic [BUS_ADDR_WIDTH-1:0] a);
    return a & ~BUS_ADDR_WIDTH'(3);
  endfunction

endpackage

// File: rtl/bus_initiator_if.sv
// Host command/response handshake plus the packed register-bus vectors.
// master = the initiator's view, slave = the host/slave-tree environment's view.
interface bus_initiator_if;
  import bus_initiator_pkg::*;

  logic                      cmd_valid;
  logic                      cmd_ready;
  logic                      cmd_we;
  logic [BUS_ADDR_WIDTH-1:0] cmd_addr;
  logic [BUS_DATA_WIDTH-1:0] cmd_wdata;
  logic                      resp_valid;
  logic                      resp_ready;
  logic [BUS_DATA_WIDTH-1:0] resp_rdata;
  logic                      resp_err;
  logic                      irq;
  logic [BUS_IN_WIDTH-1:0]   bus_in;
  logic [BUS_OUT_WIDTH-1:0]  bus_out;

  modport master (
    input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, resp_ready, bus_out,
    output cmd_ready, resp_valid, resp_rdata, resp_err, irq, bus_in
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_addr, cmd_wdata, resp_ready, bus_out,
    input  cmd_ready, resp_valid, resp_rdata, resp_err, irq, bus_in
  );

endinterface

// File: rtl/bus_initiator.sv
// Root initiator of the local register bus: takes one host command at a time,
// issues a single-cycle re/we strobe, waits for the matching ack or a timeout,
// and hands the result back to the host.
module bus_initiator
  import bus_initiator_pkg::*;
#(
  parameter int                        TIMEOUT  = 255,
  parameter logic [BUS_DATA_WIDTH-1:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic            bus_clk,
  input  logic            bus_reset,
  bus_initiator_if.master bif
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STROBE = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  localparam int                 CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t                    r_state;
  state_t                    w_next;
  logic                      r_we;
  logic [BUS_ADDR_WIDTH-1:0] r_addr;
  logic [BUS_DATA_WIDTH-1:0] r_wdata;
  logic [BUS_DATA_WIDTH-1:0] r_rdata;
  logic                      r_err;
  logic [CNT_W-1:0]          r_cnt;
  logic                      r_irq;

  logic                      w_re;
  logic                      w_we;
  logic                      w_accept;
  logic                      w_load;
  logic                      w_cnt_clr;
  logic                      w_cnt_inc;
  logic                      w_err_next;
  logic [BUS_DATA_WIDTH-1:0] w_rdata_next;
  logic                      w_rd_ack;
  logic                      w_wr_ack;
  logic                      w_ack;
  logic [BUS_DATA_WIDTH-1:0] w_rd_data;
  logic [BUS_IN_WIDTH-1:0]   w_bus_in;

  assign w_rd_ack  = bif.bus_out[BUS_FIELD_RD_ACK];
  assign w_wr_ack  = bif.bus_out[BUS_FIELD_WR_ACK];
  assign w_rd_data = bif.bus_out[BUS_RD_DATA_END:BUS_RD_DATA_START];
  // Only the ack type that matches the in-flight operation counts.
  assign w_ack     = r_we ? w_wr_ack : w_rd_ack;

  // State register plus captured command, wait counter and response payload.
  always_ff @(posedge bus_clk) begin
    if (bus_reset) begin
      r_state <= ST_IDLE;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_we    <= bif.cmd_we;
        r_addr  <= word_align(bif.cmd_addr);
        r_wdata <= bif.cmd_wdata;
      end
      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else if (w_cnt_inc) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_load) begin
        r_rdata <= w_rdata_next;
        r_err   <= w_err_next;
      end
    end
  end

  // Next-state and strobe decode; an ack in the final wait cycle beats the timeout.
  always_comb begin
    w_next       = r_state;
    w_re         = 1'b0;
    w_we         = 1'b0;
    w_accept     = 1'b0;
    w_load       = 1'b0;
    w_cnt_clr    = 1'b0;
    w_cnt_inc    = 1'b0;
    w_err_next   = 1'b0;
    w_rdata_next = '0;
    case (r_state)
      ST_IDLE: begin
        if (bif.cmd_valid) begin
          w_accept = 1'b1;
          w_next   = ST_STROBE;
        end
      end
      ST_STROBE: begin
        w_re = ~r_we;
        w_we = r_we;
        if (w_ack) begin
          w_load       = 1'b1;
          w_rdata_next = r_we ? '0 : w_rd_data;
          w_next       = ST_RESP;
        end else begin
          w_cnt_clr = 1'b1;
          w_next    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (w_ack) begin
          w_load       = 1'b1;
          w_rdata_next = r_we ? '0 : w_rd_data;
          w_next       = ST_RESP;
        end else if (r_cnt == CNT_LAST) begin
          w_load       = 1'b1;
          w_err_next   = 1'b1;
          w_rdata_next = ERR_DATA;
          w_next       = ST_RESP;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      ST_RESP: begin
        if (bif.resp_ready) begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Registered IRQ copy, decoupled from the transaction FSM.
  always_ff @(posedge bus_clk) begin
    if (bus_reset) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= bif.bus_out[BUS_FIELD_IRQ];
    end
  end

  // Pack the slave-facing vector; reset_l follows bus_reset without a register.
  always_comb begin
    w_bus_in                                       = '0;
    w_bus_in[BUS_FIELD_CLK]                        = bus_clk;
    w_bus_in[BUS_FIELD_RESET_L]                    = ~bus_reset;
    w_bus_in[BUS_FIELD_RE]                         = w_re;
    w_bus_in[BUS_FIELD_WE]                         = w_we;
    w_bus_in[BUS_ADDR_END:BUS_ADDR_START]          = r_addr;
    w_bus_in[BUS_WR_DATA_END:BUS_WR_DATA_START]    = r_wdata;
  end

  assign bif.bus_in     = w_bus_in;
  assign bif.cmd_ready  = (r_state == ST_IDLE) && !bus_reset;
  assign bif.resp_valid = (r_state == ST_RESP);
  assign bif.resp_rdata = r_rdata;
  assign bif.resp_err   = r_err;
  assign bif.irq        = r_irq;

endmodule

// File: tb/tb_bus_initiator.sv
// Directed bench for bus_initiator: instance A (TIMEOUT=8) talks to a small
// slave-register model, instance B (TIMEOUT=4) has nothing on its bus.
module tb_bus_initiator;
  import bus_initiator_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                      rst;
  logic                      sel_b;
  logic                      cmd_valid;
  logic                      cmd_we;
  logic [BUS_ADDR_WIDTH-1:0] cmd_addr;
  logic [BUS_DATA_WIDTH-1:0] cmd_wdata;
  logic                      resp_ready;
  logic                      tb_irq;
  logic                      stray_ack;

  bus_initiator_if ifa();
  bus_initiator_if ifb();

  bus_initiator #(.TIMEOUT(8), .ERR_DATA(32'hDEADBEEF)) dut_a (
    .bus_clk(clk), .bus_reset(rst), .bif(ifa.master));
  bus_initiator #(.TIMEOUT(4), .ERR_DATA(32'hDEADBEEF)) dut_b (
    .bus_clk(clk), .bus_reset(rst), .bif(ifb.master));

  assign ifa.cmd_valid  = cmd_valid & ~sel_b;
  assign ifb.cmd_valid  = cmd_valid & sel_b;
  assign ifa.cmd_we     = cmd_we;
  assign ifb.cmd_we     = cmd_we;
  assign ifa.cmd_addr   = cmd_addr;
  assign ifb.cmd_addr   = cmd_addr;
  assign ifa.cmd_wdata  = cmd_wdata;
  assign ifb.cmd_wdata  = cmd_wdata;
  assign ifa.resp_ready = resp_ready & ~sel_b;
  assign ifb.resp_ready = resp_ready & sel_b;
  assign ifb.bus_out    = '0;

  // Observed view of whichever instance is selected.
  logic                      o_cmd_ready, o_resp_valid, o_resp_err, o_irq;
  logic [BUS_DATA_WIDTH-1:0] o_resp_rdata;
  logic [BUS_IN_WIDTH-1:0]   o_bus_in;
  assign o_cmd_ready  = sel_b ? ifb.cmd_ready  : ifa.cmd_ready;
  assign o_resp_valid = sel_b ? ifb.resp_valid : ifa.resp_valid;
  assign o_resp_err   = sel_b ? ifb.resp_err   : ifa.resp_err;
  assign o_resp_rdata = sel_b ? ifb.resp_rdata : ifa.resp_rdata;
  assign o_irq        = sel_b ? ifb.irq        : ifa.irq;
  assign o_bus_in     = sel_b ? ifb.bus_in     : ifa.bus_in;

  logic                      o_re, o_we, o_rst_l;
  logic [BUS_ADDR_WIDTH-1:0] o_addr;
  logic [BUS_DATA_WIDTH-1:0] o_wdata;
  assign o_re    = o_bus_in[BUS_FIELD_RE];
  assign o_we    = o_bus_in[BUS_FIELD_WE];
  assign o_rst_l = o_bus_in[BUS_FIELD_RESET_L];
  assign o_addr  = o_bus_in[BUS_ADDR_END:BUS_ADDR_START];
  assign o_wdata = o_bus_in[BUS_WR_DATA_END:BUS_WR_DATA_START];

  // Slave model on instance A's bus.
  logic                      s_re, s_we;
  logic [BUS_ADDR_WIDTH-1:0] s_addr;
  logic [BUS_DATA_WIDTH-1:0] s_wdata;
  assign s_re    = ifa.bus_in[BUS_FIELD_RE];
  assign s_we    = ifa.bus_in[BUS_FIELD_WE];
  assign s_addr  = ifa.bus_in[BUS_ADDR_END:BUS_ADDR_START];
  assign s_wdata = ifa.bus_in[BUS_WR_DATA_END:BUS_WR_DATA_START];

  logic [31:0]               slv_reg  = 32'h0;
  int                        wr_pulse_cnt = 0;
  logic                      dly_act  = 1'b0;
  int                        dly_cnt  = 0;
  logic [BUS_ADDR_WIDTH-1:0] dly_addr = '0;
  int                        overlap_cnt = 0;

  always @(posedge clk) begin
    if (s_we && s_addr == 16'h0010) begin
      slv_reg      <= s_wdata;
      wr_pulse_cnt <= wr_pulse_cnt + 1;
    end
    if (s_re) begin
      dly_act  <= 1'b1;
      dly_cnt  <= 1;
      dly_addr <= s_addr;
    end else if (dly_act) begin
      dly_cnt <= dly_cnt + 1;
    end
  end

  logic [BUS_OUT_WIDTH-1:0] a_out;
  always_comb begin
    a_out = '0;
    a_out[BUS_FIELD_IRQ] = tb_irq;
    if (stray_ack) begin
      a_out[BUS_FIELD_RD_ACK] = 1'b1;
      a_out[BUS_FIELD_WR_ACK] = 1'b1;
      a_out[BUS_RD_DATA_END:BUS_RD_DATA_START] = 32'hBAD0BAD0;
    end
    if (s_re && s_addr == 16'h0020) begin
      a_out[BUS_FIELD_RD_ACK] = 1'b1;
      a_out[BUS_RD_DATA_END:BUS_RD_DATA_START] = 32'h12345678;
    end
    if (s_re && s_addr == 16'h0010) begin
      a_out[BUS_FIELD_RD_ACK] = 1'b1;
      a_out[BUS_RD_DATA_END:BUS_RD_DATA_START] = slv_reg;
    end
    if (s_we && s_addr == 16'h0010) a_out[BUS_FIELD_WR_ACK] = 1'b1;
    if (dly_act && !s_re && dly_addr == 16'h0040 && dly_cnt == 5) begin
      a_out[BUS_FIELD_RD_ACK] = 1'b1;
      a_out[BUS_RD_DATA_END:BUS_RD_DATA_START] = 32'hCAFE0001;
    end
    if (dly_act && !s_re && dly_addr == 16'h0050 && dly_cnt == 2) a_out[BUS_FIELD_WR_ACK] = 1'b1;
    if (dly_act && !s_re && dly_addr == 16'h0050 && dly_cnt == 4) begin
      a_out[BUS_FIELD_RD_ACK] = 1'b1;
      a_out[BUS_RD_DATA_END:BUS_RD_DATA_START] = 32'hA5A55A5A;
    end
  end
  assign ifa.bus_out = a_out;

  always @(negedge clk) begin
    if ((ifa.cmd_ready && ifa.resp_valid) || (ifb.cmd_ready && ifb.resp_valid))
      overlap_cnt <= overlap_cnt + 1;
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One complete host transaction with latency, strobe and response checks.
  task automatic do_cmd(input logic sel, input logic we, input logic [15:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata,
                        input logic exp_err, input int exp_lat, input logic [15:0] exp_addr);
    exp_t e, got_e;
    int   lat, re_n, we_n, both_n, addr_bad;
    logic got;
    logic [31:0] wd_seen;
    logic [31:0] rd0;
    logic        er0;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    sb_q.push_back(e);
    @(negedge clk);
    sel_b = sel; cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_wdata = wdata;
    #1;
    check("cmd_ready_idle", o_cmd_ready, 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    lat = 1; re_n = 0; we_n = 0; both_n = 0; addr_bad = 0; got = 1'b0; wd_seen = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      re_n   += int'(o_re);
      we_n   += int'(o_we);
      both_n += int'(o_re & o_we);
      if (o_we) wd_seen = o_wdata;
      if (o_addr !== exp_addr) addr_bad++;
      if (o_resp_valid) begin
        got = 1'b1;
        break;
      end
      lat++;
    end
    check("resp_seen", got, 1);
    check("resp_latency", lat, exp_lat);
    check("re_cycles", re_n, we ? 0 : 1);
    check("we_cycles", we_n, we ? 1 : 0);
    check("re_we_both", both_n, 0);
    check("addr_held", addr_bad, 0);
    if (we) check("bus_wdata", wd_seen, wdata);
    rd0 = o_resp_rdata;
    er0 = o_resp_err;
    @(negedge clk);
    check("resp_hold_valid", o_resp_valid, 1);
    check("resp_hold_rdata", o_resp_rdata, rd0);
    check("resp_hold_err", o_resp_err, er0);
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    got_e = sb_q.pop_front();
    check("resp_rdata", rd0, got_e.rdata);
    check("resp_err", er0, got_e.err);
    @(negedge clk);
    check("resp_cleared", o_resp_valid, 0);
    check("cmd_ready_back", o_cmd_ready, 1);
  endtask

  int wp0;
  int bad_cnt;

  initial begin
    sel_b = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    resp_ready = 1'b0; stray_ack = 1'b0; tb_irq = 1'b1; rst = 1'b1;
    repeat (3) @(negedge clk);
    // Reset values
    check("rst_cmd_ready", o_cmd_ready, 0);
    check("rst_resp_valid", o_resp_valid, 0);
    check("rst_resp_rdata", o_resp_rdata, 0);
    check("rst_resp_err", o_resp_err, 0);
    check("rst_irq", o_irq, 0);
    check("rst_re_we", {o_re, o_we}, 0);
    check("rst_addr", o_addr, 0);
    check("rst_wdata", o_wdata, 0);
    check("rst_reset_l", o_rst_l, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_cmd_ready", o_cmd_ready, 1);
    check("idle_reset_l", o_rst_l, 1);
    check("irq_set", o_irq, 1);
    tb_irq = 1'b0;
    #1;
    check("irq_registered", o_irq, 1);
    @(negedge clk);
    check("irq_clear", o_irq, 0);

    // Zero-wait read
    do_cmd(1'b0, 1'b0, 16'h0020, 32'h0, 32'h12345678, 1'b0, 2, 16'h0020);

    // Write to unaligned byte address lands on the word register
    wp0 = wr_pulse_cnt;
    do_cmd(1'b0, 1'b1, 16'h0013, 32'hA1B2C3D4, 32'h0, 1'b0, 2, 16'h0010);
    check("wr_pulse_once", wr_pulse_cnt - wp0, 1);
    check("slave_reg", slv_reg, 32'hA1B2C3D4);
    do_cmd(1'b0, 1'b0, 16'h0012, 32'h0, 32'hA1B2C3D4, 1'b0, 2, 16'h0010);

    // Acks while idle are ignored
    @(negedge clk);
    stray_ack = 1'b1;
    bad_cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (o_resp_valid !== 1'b0 || o_cmd_ready !== 1'b1) bad_cnt++;
    end
    stray_ack = 1'b0;
    check("idle_ack_ignored", bad_cnt, 0);

    // Delayed ack, then wrong-type ack followed by the real one
    do_cmd(1'b0, 1'b0, 16'h0040, 32'h0, 32'hCAFE0001, 1'b0, 7, 16'h0040);
    do_cmd(1'b0, 1'b0, 16'h0050, 32'h0, 32'hA5A55A5A, 1'b0, 6, 16'h0050);

    // Timeout on the empty bus
    do_cmd(1'b1, 1'b0, 16'h0080, 32'h0, 32'hDEADBEEF, 1'b1, 6, 16'h0080);
    sel_b = 1'b0;

    // Reset in the middle of a wait
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 16'h0060;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_resp_valid", o_resp_valid, 0);
    check("midrst_cmd_ready", o_cmd_ready, 0);
    check("midrst_re_we", {o_re, o_we}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_idle", o_cmd_ready, 1);
    bad_cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (o_resp_valid !== 1'b0 || o_re !== 1'b0) bad_cnt++;
    end
    check("midrst_no_resp", bad_cnt, 0);

    check("valid_ready_overlap", overlap_cnt, 0);
    check("scoreboard_empty", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
